// File: rtl/scan_core_engine_mc.sv
// Multi-channel Mamba selective-scan step engine: one recurrence step per accepted
// token over CH independent hidden-state banks of N lanes; exp() is evaluated externally.
module scan_core_engine_mc #(
    parameter  int DATA_WIDTH = 16,
    parameter  int FRAC_BITS  = 8,
    parameter  int N          = 16,
    parameter  int CH         = 4,
    parameter  int USE_GATE   = 1,
    localparam int CH_W       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CH_W-1:0]              in_ch,
    input  logic [DATA_WIDTH-1:0]        delta_val,
    input  logic [DATA_WIDTH-1:0]        x_val,
    input  logic [DATA_WIDTH-1:0]        D_val,
    input  logic [DATA_WIDTH-1:0]        gate_val,
    input  logic [N*DATA_WIDTH-1:0]      A_vec,
    input  logic [N*DATA_WIDTH-1:0]      B_vec,
    input  logic [N*DATA_WIDTH-1:0]      C_vec,
    input  logic                         clear_all,
    input  logic                         clear_ch_en,
    input  logic [CH_W-1:0]              clear_ch,
    output logic [N*DATA_WIDTH-1:0]      exp_arg_vec,
    input  logic [N*DATA_WIDTH-1:0]      exp_res_vec,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        y_out,
    output logic [CH_W-1:0]              y_ch,
    output logic                         sat_flag
);

    localparam int DW    = DATA_WIDTH;
    localparam int ACC_W = DATA_WIDTH + $clog2(N) + 1;
    localparam int WIDE  = (ACC_W > 2 * DATA_WIDTH) ? ACC_W : 2 * DATA_WIDTH;

    typedef logic signed [DW-1:0]   word_t;
    typedef logic signed [WIDE-1:0] wide_t;

    localparam wide_t SAT_MAX = {{(WIDE-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam wide_t SAT_MIN = {{(WIDE-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DA,
        S_EXP,
        S_CAP,
        S_H,
        S_Y,
        S_OUT_PREP,
        S_OUT
    } state_t;

    // Results are packed as {clamped, value}.
    function automatic logic [DW:0] f_sat(input wide_t v);
        if (v > SAT_MAX)      f_sat = {1'b1, SAT_MAX[DW-1:0]};
        else if (v < SAT_MIN) f_sat = {1'b1, SAT_MIN[DW-1:0]};
        else                  f_sat = {1'b0, v[DW-1:0]};
    endfunction

    function automatic logic [DW:0] f_mul(input word_t a, input word_t b);
        wide_t p;
        p = (WIDE'(a) * WIDE'(b)) >>> FRAC_BITS;
        f_mul = f_sat(p);
    endfunction

    function automatic logic [DW:0] f_add(input word_t a, input word_t b);
        f_add = f_sat(WIDE'(a) + WIDE'(b));
    endfunction

    function automatic logic [(2**CH_W)-1:0] f_ch_mask();
        f_ch_mask = '0;
        for (int unsigned c = 0; c < CH; c++) f_ch_mask[c] = 1'b1;
    endfunction

    localparam logic [(2**CH_W)-1:0] CH_MASK = f_ch_mask();

    state_t                   r_state;
    word_t                    r_delta, r_x, r_D, r_gate;
    logic [N*DW-1:0]          r_A_vec, r_B_vec, r_C_vec;
    logic [N*DW-1:0]          r_dA_vec, r_discA_vec, r_dBx_vec;
    logic [CH_W-1:0]          r_ch;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_sticky;
    logic                     r_out_valid;
    logic                     r_sat_flag;
    word_t                    r_y;
    logic [CH_W-1:0]          r_y_ch;
    word_t                    r_h [CH][N];

    logic                     w_ch_ok;
    word_t                    w_h_cur [N];
    logic [N*DW-1:0]          w_dA_vec, w_dBx_vec, w_h_new_vec;
    logic                     w_dA_sat, w_dBx_sat, w_h_sat, w_acc_sat, w_prep_sat;
    logic signed [ACC_W-1:0]  w_acc;
    word_t                    w_y_prep;

    assign w_ch_ok     = CH_MASK[r_ch];
    assign in_ready    = (r_state == S_IDLE) && !reset;
    assign exp_arg_vec = r_dA_vec;
    assign out_valid   = r_out_valid;
    assign y_out       = r_y;
    assign y_ch        = r_y_ch;
    assign sat_flag    = r_sat_flag;

    // Before S_H this is h_old; from S_Y on the bank already holds h_new (or a clear).
    always_comb begin
        for (int unsigned i = 0; i < N; i++)
            w_h_cur[i] = w_ch_ok ? r_h[r_ch][i] : '0;
    end

    always_comb begin
        logic [DW:0] t1, t2;
        word_t       tw;
        w_dA_vec    = '0;
        w_dBx_vec   = '0;
        w_h_new_vec = '0;
        w_dA_sat    = 1'b0;
        w_dBx_sat   = 1'b0;
        w_h_sat     = 1'b0;
        w_acc_sat   = 1'b0;
        w_acc       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            t1 = f_mul(r_delta, r_A_vec[i*DW +: DW]);
            w_dA_vec[i*DW +: DW] = t1[DW-1:0];
            w_dA_sat = w_dA_sat | t1[DW];

            t1 = f_mul(r_delta, r_B_vec[i*DW +: DW]);
            t2 = f_mul(t1[DW-1:0], r_x);
            w_dBx_vec[i*DW +: DW] = t2[DW-1:0];
            w_dBx_sat = w_dBx_sat | t1[DW] | t2[DW];

            t1 = f_mul(r_discA_vec[i*DW +: DW], w_h_cur[i]);
            t2 = f_add(t1[DW-1:0], r_dBx_vec[i*DW +: DW]);
            w_h_new_vec[i*DW +: DW] = t2[DW-1:0];
            w_h_sat = w_h_sat | t1[DW] | t2[DW];

            t1 = f_mul(r_C_vec[i*DW +: DW], w_h_cur[i]);
            tw = t1[DW-1:0];
            w_acc = w_acc + ACC_W'(tw);
            w_acc_sat = w_acc_sat | t1[DW];
        end
        t1 = f_mul(r_D, r_x);
        tw = t1[DW-1:0];
        w_acc = w_acc + ACC_W'(tw);
        w_acc_sat = w_acc_sat | t1[DW];
    end

    always_comb begin
        logic [DW:0] s, g;
        s          = f_sat(WIDE'(r_acc));
        g          = f_mul(s[DW-1:0], r_gate);
        w_y_prep   = s[DW-1:0];
        w_prep_sat = s[DW];
        if (USE_GATE != 0) begin
            w_y_prep   = g[DW-1:0];
            w_prep_sat = s[DW] | g[DW];
        end
        if (!w_ch_ok) begin
            w_y_prep   = '0;
            w_prep_sat = 1'b0;
        end
    end

    // A clear always beats the S_H write-back for the same bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < CH; c++)
                for (int unsigned i = 0; i < N; i++)
                    r_h[c][i] <= '0;
        end else begin
            for (int unsigned c = 0; c < CH; c++) begin
                if (clear_all || (clear_ch_en && clear_ch == CH_W'(c))) begin
                    for (int unsigned i = 0; i < N; i++) r_h[c][i] <= '0;
                end else if (r_state == S_H && w_ch_ok && r_ch == CH_W'(c)) begin
                    for (int unsigned i = 0; i < N; i++)
                        r_h[c][i] <= w_h_new_vec[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_delta     <= '0;
            r_x         <= '0;
            r_D         <= '0;
            r_gate      <= '0;
            r_A_vec     <= '0;
            r_B_vec     <= '0;
            r_C_vec     <= '0;
            r_dA_vec    <= '0;
            r_discA_vec <= '0;
            r_dBx_vec   <= '0;
            r_ch        <= '0;
            r_acc       <= '0;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
            r_sat_flag  <= 1'b0;
            r_y         <= '0;
            r_y_ch      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_delta  <= delta_val;
                        r_x      <= x_val;
                        r_D      <= D_val;
                        r_gate   <= gate_val;
                        r_A_vec  <= A_vec;
                        r_B_vec  <= B_vec;
                        r_C_vec  <= C_vec;
                        r_ch     <= in_ch;
                        r_sticky <= 1'b0;
                        r_state  <= S_DA;
                    end
                end
                S_DA: begin
                    r_dA_vec <= w_dA_vec;
                    r_sticky <= r_sticky | w_dA_sat;
                    r_state  <= S_EXP;
                end
                S_EXP: r_state <= S_CAP;
                S_CAP: begin
                    r_discA_vec <= exp_res_vec;
                    r_dBx_vec   <= w_dBx_vec;
                    r_sticky    <= r_sticky | w_dBx_sat;
                    r_state     <= S_H;
                end
                S_H: begin
                    r_sticky <= r_sticky | (w_ch_ok & w_h_sat);
                    r_state  <= S_Y;
                end
                S_Y: begin
                    r_acc    <= w_ch_ok ? w_acc : '0;
                    r_sticky <= r_sticky | (w_ch_ok & w_acc_sat);
                    r_state  <= S_OUT_PREP;
                end
                S_OUT_PREP: begin
                    r_y         <= w_y_prep;
                    r_y_ch      <= r_ch;
                    r_sat_flag  <= r_sticky | w_prep_sat;
                    r_sticky    <= r_sticky | w_prep_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_core_engine_mc.sv
// Directed self-checking bench for scan_core_engine_mc (Q8.8, N=16, CH=4, gated).
module tb_scan_core_engine_mc;

    localparam int DW   = 16;
    localparam int N    = 16;
    localparam int CH   = 4;
    localparam int CH_W = 2;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch;
    logic [DW-1:0]     delta_val, x_val, D_val, gate_val;
    logic [N*DW-1:0]   A_vec, B_vec, C_vec;
    logic              clear_all;
    logic              clear_ch_en;
    logic [CH_W-1:0]   clear_ch;
    logic [N*DW-1:0]   exp_arg_vec;
    logic [N*DW-1:0]   exp_res_vec;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     y_out;
    logic [CH_W-1:0]   y_ch;
    logic              sat_flag;

    int checks = 0;
    int errors = 0;

    scan_core_engine_mc #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (8),
        .N          (16),
        .CH         (4),
        .USE_GATE   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ch       (in_ch),
        .delta_val   (delta_val),
        .x_val       (x_val),
        .D_val       (D_val),
        .gate_val    (gate_val),
        .A_vec       (A_vec),
        .B_vec       (B_vec),
        .C_vec       (C_vec),
        .clear_all   (clear_all),
        .clear_ch_en (clear_ch_en),
        .clear_ch    (clear_ch),
        .exp_arg_vec (exp_arg_vec),
        .exp_res_vec (exp_res_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y_out       (y_out),
        .y_ch        (y_ch),
        .sat_flag    (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First-order exp model: 1.0 + arg, exactly 1.0 (256) at argument 0.
    always_comb begin
        exp_res_vec = '0;
        for (int i = 0; i < N; i++)
            exp_res_vec[i*DW +: DW] = exp_arg_vec[i*DW +: DW] + 16'd256;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish in time");
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_ops(input logic [CH_W-1:0] ch, input int dlt, input int xv,
                           input int dv, input int gv, input int bv, input int cv);
        in_ch     = ch;
        delta_val = dlt[15:0];
        x_val     = xv[15:0];
        D_val     = dv[15:0];
        gate_val  = gv[15:0];
        A_vec     = '0;
        B_vec     = {N{bv[15:0]}};
        C_vec     = {N{cv[15:0]}};
    endtask

    task automatic set_clr(input logic en, input logic [CH_W-1:0] cch);
        clear_ch_en = en;
        clear_ch    = cch;
    endtask

    // clr_at: edge index (0 = accept edge) on which a per-channel clear of cch lands; -1 for none.
    task automatic run_step(input string tag, input logic [CH_W-1:0] ch,
                            input int dlt, input int xv, input int dv, input int gv,
                            input int bv, input int cv,
                            input int clr_at, input logic [CH_W-1:0] cch, input int hold,
                            input int exp_y, input int exp_sat);
        int lat;
        @(negedge clk);
        set_ops(ch, dlt, xv, dv, gv, bv, cv);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        set_clr(clr_at == 0, cch);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        set_clr(clr_at == 1, cch);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            set_clr(clr_at == lat + 1, cch);
            if (lat == 2) chk({tag, "_exp_arg"}, int'(|exp_arg_vec), 0);
        end
        set_clr(1'b0, cch);
        chk({tag, "_latency"}, lat, 6);
        chk({tag, "_y_out"}, int'($signed(y_out)), exp_y);
        chk({tag, "_y_ch"}, int'(y_ch), int'(ch));
        chk({tag, "_sat"}, int'(sat_flag), exp_sat);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, int'(out_valid), 1);
            chk({tag, "_hold_y"}, int'($signed(y_out)), exp_y);
            chk({tag, "_hold_ych"}, int'(y_ch), int'(ch));
            chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_drain_valid"}, int'(out_valid), 0);
        chk({tag, "_idle_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        clear_all   = 1'b0;
        clear_ch_en = 1'b0;
        clear_ch    = '0;
        set_ops(2'd0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_sat", int'(sat_flag), 0);
        chk("rst_exp_arg", int'(|exp_arg_vec), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Banks accumulate 512 per lane per step: y = 16*h.
        run_step("t1_ch0",   2'd0, 256, 512, 0, 256, 256, 256, -1, 2'd0, 0,  8192, 0);
        run_step("t2_ch0",   2'd0, 256, 512, 0, 256, 256, 256, -1, 2'd0, 0, 16384, 0);
        run_step("t2_ch1",   2'd1, 256, 512, 0, 256, 256, 256, -1, 2'd0, 0,  8192, 0);
        run_step("t3_ch0",   2'd0, 256, 512, 0, 256, 256, 256, -1, 2'd0, 0, 24576, 0);
        run_step("t4_sat",   2'd0, 256, 512, 0, 256, 256, 256, -1, 2'd0, 10, 32767, 1);

        run_step("t5_clr_acc", 2'd0, 256, 512, 0, 256, 256, 256, 0, 2'd0, 0, 8192, 0);
        @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        run_step("t5_clr_all", 2'd1, 256, 512, 0, 256, 256, 256, -1, 2'd0, 0, 8192, 0);

        run_step("t6_gate",  2'd2, 256, 512, 0, -128, 256, 256, -1, 2'd0, 0, -4096, 0);

        run_step("t7_clr_h",   2'd3, 256, 512, 0, 256, 256, 256, 4, 2'd3, 0, 0, 0);
        run_step("t7_after_h", 2'd3, 256, 512, 0, 256, 256, 256, -1, 2'd0, 0, 8192, 0);

        @(negedge clk);
        set_ops(2'd0, 256, 512, 0, 256, 256, 256);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t8_rst_out_valid", int'(out_valid), 0);
        chk("t8_rst_in_ready", int'(in_ready), 0);
        chk("t8_rst_y_out", int'(y_out), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t8_rst_hold_valid", int'(out_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t8_post_rst_ready", int'(in_ready), 1);
        run_step("t8_fresh", 2'd0, 256, 512, 0, 256, 256, 256, -1, 2'd0, 0, 8192, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
